// File: rtl/dht11_poll_scheduler.sv
// DHT11 poll scheduler: periodic/early read triggering, timeout and retry handling, result publishing.
// rd_start/rd_abort are combinational from state; results and upd_stb land one cycle after rd_done; no backpressure.
module dht11_poll_scheduler #(
  parameter int unsigned PERIOD_US    = 2_000_000,
  parameter int unsigned TIMEOUT_US   = 30_000,
  parameter int unsigned RETRY_GAP_US = 1_000_000,
  parameter int unsigned MIN_GAP_US   = 1_000_000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       reset,
  input  logic       clk1Mhz,
  input  logic       enable,
  input  logic       trigger_now,
  output logic       rd_start,
  output logic       rd_abort,
  input  logic       rd_done,
  input  logic       rd_crc_ok,
  input  logic [7:0] rd_hum,
  input  logic [7:0] rd_temp,
  output logic [7:0] humidity,
  output logic [7:0] temperature,
  output logic       data_valid,
  output logic       upd_stb,
  output logic       fault,
  output logic [7:0] err_count,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_GAP   = 3'd1,
    START      = 3'd2,
    WAIT_DONE  = 3'd3,
    RETRY_WAIT = 3'd4
  } state_t;

  localparam logic [21:0] PERIOD_END  = 22'(PERIOD_US - 1);
  localparam logic [21:0] TIMEOUT_END = 22'(TIMEOUT_US - 1);
  localparam logic [21:0] RETRY_END   = 22'(RETRY_GAP_US - 1);
  localparam logic [21:0] MIN_GAP_END = 22'(MIN_GAP_US - 1);
  localparam logic [4:0]  RETRY_LIMIT = 5'(MAX_RETRY);

  state_t      state;
  state_t      state_nxt;
  logic [21:0] us_cnt;
  logic [3:0]  retry_cnt;
  logic        read_ok;
  logic        read_fail;
  logic        drop_retry;
  logic        last_try;

  assign last_try  = ({1'b0, retry_cnt} + 5'd1) >= RETRY_LIMIT;
  assign state_dbg = state;

  always_comb begin
    state_nxt  = state;
    rd_start   = 1'b0;
    rd_abort   = 1'b0;
    read_ok    = 1'b0;
    read_fail  = 1'b0;
    drop_retry = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = WAIT_GAP;
      end
      WAIT_GAP: begin
        if (!enable)
          state_nxt = IDLE;
        else if (us_cnt == PERIOD_END || (trigger_now && us_cnt >= MIN_GAP_END))
          state_nxt = START;
      end
      START: begin
        rd_start  = 1'b1;
        state_nxt = enable ? WAIT_DONE : IDLE;
      end
      WAIT_DONE: begin
        if (!enable) begin
          rd_abort   = 1'b1;
          drop_retry = 1'b1;
          state_nxt  = IDLE;
        end else if (rd_done) begin
          // a frame arriving on the timeout cycle still counts as an answer
          if (rd_crc_ok) begin
            read_ok   = 1'b1;
            state_nxt = WAIT_GAP;
          end else begin
            read_fail = 1'b1;
          end
        end else if (us_cnt == TIMEOUT_END) begin
          read_fail = 1'b1;
          rd_abort  = 1'b1;
        end
        if (read_fail) state_nxt = last_try ? WAIT_GAP : RETRY_WAIT;
      end
      RETRY_WAIT: begin
        if (!enable)
          state_nxt = IDLE;
        else if (us_cnt == RETRY_END)
          state_nxt = START;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1Mhz or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      us_cnt      <= '0;
      retry_cnt   <= '0;
      humidity    <= '0;
      temperature <= '0;
      data_valid  <= 1'b0;
      fault       <= 1'b0;
      err_count   <= '0;
      upd_stb     <= 1'b0;
    end else begin
      state   <= state_nxt;
      us_cnt  <= (state_nxt != state) ? 22'd0 : us_cnt + 22'd1;
      upd_stb <= read_ok;
      if (read_ok) begin
        humidity    <= rd_hum;
        temperature <= rd_temp;
        data_valid  <= 1'b1;
        fault       <= 1'b0;
        retry_cnt   <= '0;
      end
      if (read_fail) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (last_try) begin
          fault      <= 1'b1;
          data_valid <= 1'b0;
          retry_cnt  <= '0;
        end else begin
          retry_cnt  <= retry_cnt + 4'd1;
        end
      end
      if (drop_retry) retry_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// Directed bench for dht11_poll_scheduler; inputs driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_dht11_poll_scheduler;

  logic       reset;
  logic       clk1Mhz;
  logic       enable;
  logic       trigger_now;
  logic       rd_start;
  logic       rd_abort;
  logic       rd_done;
  logic       rd_crc_ok;
  logic [7:0] rd_hum;
  logic [7:0] rd_temp;
  logic [7:0] humidity;
  logic [7:0] temperature;
  logic       data_valid;
  logic       upd_stb;
  logic       fault;
  logic [7:0] err_count;
  logic [2:0] state_dbg;

  int n_cmp;
  int n_bad;

  dht11_poll_scheduler #(
    .PERIOD_US   (100),
    .TIMEOUT_US  (50),
    .RETRY_GAP_US(20),
    .MIN_GAP_US  (10),
    .MAX_RETRY   (3)
  ) dut (
    .reset      (reset),
    .clk1Mhz    (clk1Mhz),
    .enable     (enable),
    .trigger_now(trigger_now),
    .rd_start   (rd_start),
    .rd_abort   (rd_abort),
    .rd_done    (rd_done),
    .rd_crc_ok  (rd_crc_ok),
    .rd_hum     (rd_hum),
    .rd_temp    (rd_temp),
    .humidity   (humidity),
    .temperature(temperature),
    .data_valid (data_valid),
    .upd_stb    (upd_stb),
    .fault      (fault),
    .err_count  (err_count),
    .state_dbg  (state_dbg)
  );

  initial clk1Mhz = 1'b0;
  always #5 clk1Mhz = ~clk1Mhz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts falling edges until rd_start is seen, bounded by lim.
  task automatic wait_start(input int lim, output int n, output int upd_seen);
    n = 0;
    upd_seen = 0;
    do begin
      @(negedge clk1Mhz);
      n++;
      if (upd_stb) upd_seen++;
    end while (!rd_start && n < lim);
  endtask

  task automatic wait_abort(input int lim, output int n, output int overlap);
    n = 0;
    overlap = 0;
    do begin
      @(negedge clk1Mhz);
      n++;
      if (rd_start && rd_abort) overlap++;
    end while (!rd_abort && n < lim);
  endtask

  task automatic frame(input logic ok, input logic [7:0] h, input logic [7:0] t);
    rd_done   = 1'b1;
    rd_crc_ok = ok;
    rd_hum    = h;
    rd_temp   = t;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state_dbg), 32'd0);
    chk({tag, "_hum"}, 32'(humidity), 32'd0);
    chk({tag, "_temp"}, 32'(temperature), 32'd0);
    chk({tag, "_dv"}, 32'(data_valid), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_upd"}, 32'(upd_stb), 32'd0);
    chk({tag, "_start"}, 32'(rd_start), 32'd0);
    chk({tag, "_abort"}, 32'(rd_abort), 32'd0);
  endtask

  initial begin
    int n;
    int u;
    int ov;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    enable = 1'b0;
    trigger_now = 1'b0;
    rd_done = 1'b0;
    rd_crc_ok = 1'b0;
    rd_hum = 8'h00;
    rd_temp = 8'h00;

    repeat (3) @(negedge clk1Mhz);
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (5) @(negedge clk1Mhz);
    chk("idle_hold", 32'(state_dbg), 32'd0);

    // Periodic read: first rd_start 101 edges counting the one that samples enable
    enable = 1'b1;
    wait_start(300, n, u);
    chk("first_start_dly", 32'(n), 32'd101);
    chk("start_state", 32'(state_dbg), 32'd2);
    @(negedge clk1Mhz);
    chk("wait_done_state", 32'(state_dbg), 32'd3);
    repeat (4) @(negedge clk1Mhz);
    frame(1'b1, 8'h2D, 8'h17);
    @(negedge clk1Mhz);
    rd_done = 1'b0;
    chk("ok_state", 32'(state_dbg), 32'd1);
    chk("ok_hum", 32'(humidity), 32'd45);
    chk("ok_temp", 32'(temperature), 32'd23);
    chk("ok_dv", 32'(data_valid), 32'd1);
    chk("ok_upd", 32'(upd_stb), 32'd1);
    wait_start(300, n, u);
    chk("period_dly", 32'(n), 32'd100);
    chk("upd_single", 32'(u), 32'd0);

    // Early trigger: too early at counter 5, honoured at counter 12
    @(negedge clk1Mhz);
    frame(1'b1, 8'h30, 8'h18);
    @(negedge clk1Mhz);
    rd_done = 1'b0;
    repeat (5) @(negedge clk1Mhz);
    trigger_now = 1'b1;
    @(negedge clk1Mhz);
    trigger_now = 1'b0;
    chk("trig_early_ignored", 32'(state_dbg), 32'd1);
    repeat (6) @(negedge clk1Mhz);
    trigger_now = 1'b1;
    @(negedge clk1Mhz);
    trigger_now = 1'b0;
    chk("trig_state", 32'(state_dbg), 32'd2);
    chk("trig_start", 32'(rd_start), 32'd1);

    // Retry then succeed
    @(negedge clk1Mhz);
    frame(1'b0, 8'hEE, 8'hEE);
    @(negedge clk1Mhz);
    rd_done = 1'b0;
    chk("crc_bad_state", 32'(state_dbg), 32'd4);
    chk("crc_bad_err", 32'(err_count), 32'd1);
    chk("crc_bad_hum_kept", 32'(humidity), 32'h30);
    wait_start(300, n, u);
    chk("retry_gap", 32'(n), 32'd20);
    @(negedge clk1Mhz);
    frame(1'b1, 8'h33, 8'h19);
    @(negedge clk1Mhz);
    rd_done = 1'b0;
    chk("retry_ok_hum", 32'(humidity), 32'h33);
    chk("retry_ok_temp", 32'(temperature), 32'h19);
    chk("retry_ok_fault", 32'(fault), 32'd0);
    chk("retry_ok_upd", 32'(upd_stb), 32'd1);

    // Persistent timeout: three aborts, then fault
    wait_start(300, n, u);
    chk("to_first_start", 32'(n), 32'd100);
    for (int i = 0; i < 3; i++) begin
      wait_abort(300, n, ov);
      chk($sformatf("to_abort_dly%0d", i), 32'(n), 32'd50);
      chk($sformatf("to_overlap%0d", i), 32'(ov), 32'd0);
      if (i < 2) begin
        wait_start(300, n, u);
        chk($sformatf("to_retry_dly%0d", i), 32'(n), 32'd21);
      end
    end
    @(negedge clk1Mhz);
    chk("to_state", 32'(state_dbg), 32'd1);
    chk("to_err", 32'(err_count), 32'd4);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_dv", 32'(data_valid), 32'd0);
    chk("to_hum_kept", 32'(humidity), 32'h33);
    chk("to_temp_kept", 32'(temperature), 32'h19);

    // rd_done on the timeout cycle wins
    wait_start(300, n, u);
    repeat (50) @(negedge clk1Mhz);
    frame(1'b1, 8'h40, 8'h1A);
    #1;
    chk("edge_no_abort", 32'(rd_abort), 32'd0);
    @(negedge clk1Mhz);
    rd_done = 1'b0;
    chk("edge_state", 32'(state_dbg), 32'd1);
    chk("edge_hum", 32'(humidity), 32'h40);
    chk("edge_fault", 32'(fault), 32'd0);
    chk("edge_dv", 32'(data_valid), 32'd1);
    chk("edge_err", 32'(err_count), 32'd4);

    // enable drop during WAIT_DONE
    wait_start(300, n, u);
    @(negedge clk1Mhz);
    enable = 1'b0;
    #1;
    chk("dis_abort", 32'(rd_abort), 32'd1);
    @(negedge clk1Mhz);
    chk("dis_state", 32'(state_dbg), 32'd0);
    chk("dis_abort_once", 32'(rd_abort), 32'd0);
    chk("dis_hum", 32'(humidity), 32'h40);
    chk("dis_temp", 32'(temperature), 32'h1A);
    chk("dis_dv", 32'(data_valid), 32'd1);
    chk("dis_err", 32'(err_count), 32'd4);

    // Reset mid-transaction
    enable = 1'b1;
    wait_start(300, n, u);
    chk("reenable_dly", 32'(n), 32'd101);
    @(negedge clk1Mhz);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (60) @(negedge clk1Mhz);
    chk("midrst_no_abort", 32'(rd_abort), 32'd0);
    chk("midrst_hold", 32'(state_dbg), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
